// File: rtl/dump_cntrl.sv
// Streams a finished capture out of the circular sample RAM to the UART TX,
// oldest sample first, one byte per read/latch/send/wait round trip.
module dump_cntrl #(
  parameter int ENTRIES = 384,
  parameter int LOG2    = 9
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_dump_en,
  input  logic [2:0]      i_dump_chan,
  input  logic [LOG2-1:0] i_waddr,
  input  logic [7:0]      i_rdata,
  input  logic            i_tx_done,
  output logic [2:0]      o_ch_sel,
  output logic [LOG2-1:0] o_raddr,
  output logic            o_ren,
  output logic [7:0]      o_tx_data,
  output logic            o_trmt,
  output logic            o_busy,
  output logic            o_dump_done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ   = 3'd1,
    LATCH  = 3'd2,
    SEND   = 3'd3,
    TXWAIT = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam logic [LOG2-1:0] LAST = LOG2'(ENTRIES - 1);

  state_t          r_state;
  state_t          w_next;
  logic [2:0]      r_ch_sel;
  logic [LOG2-1:0] r_raddr;
  logic [LOG2-1:0] r_byte_cnt;
  logic [7:0]      r_tx_data;
  logic            w_chan_ok;
  logic            w_advance;

  assign w_chan_ok = (i_dump_chan != 3'd0) && (i_dump_chan < 3'd6);
  // Only a tx_done seen while waiting on the UART moves the dump forward.
  assign w_advance = (r_state == TXWAIT) && i_tx_done;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (i_dump_en) begin
          w_next = w_chan_ok ? READ : DONE;
        end else begin
          w_next = IDLE;
        end
      end
      READ:   w_next = LATCH;
      LATCH:  w_next = SEND;
      SEND:   w_next = TXWAIT;
      TXWAIT: begin
        if (i_tx_done) begin
          w_next = (r_byte_cnt == LAST) ? DONE : READ;
        end else begin
          w_next = TXWAIT;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Datapath: channel/address capture, byte counting with wrap, data latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ch_sel   <= 3'd0;
      r_raddr    <= '0;
      r_byte_cnt <= '0;
      r_tx_data  <= 8'h00;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_dump_en && w_chan_ok) begin
            r_ch_sel   <= i_dump_chan;
            r_raddr    <= i_waddr;
            r_byte_cnt <= '0;
          end
        end
        LATCH: r_tx_data <= i_rdata;
        TXWAIT: begin
          if (w_advance && (r_byte_cnt != LAST)) begin
            r_byte_cnt <= r_byte_cnt + LOG2'(1);
            r_raddr    <= (r_raddr == LAST) ? '0 : r_raddr + LOG2'(1);
          end
        end
        default: begin
          r_ch_sel <= r_ch_sel;
        end
      endcase
    end
  end

  assign o_ch_sel    = r_ch_sel;
  assign o_raddr     = r_raddr;
  assign o_tx_data   = r_tx_data;
  assign o_ren       = (r_state == READ);
  assign o_trmt      = (r_state == SEND);
  assign o_dump_done = (r_state == DONE);
  assign o_busy      = (r_state == READ) || (r_state == LATCH) ||
                       (r_state == SEND) || (r_state == TXWAIT);

endmodule

// File: tb/tb_dump_cntrl.sv
// Directed bench for dump_cntrl: a table of dump scenarios plus hand-written
// sequences for noisy inputs, reset mid-stream and back-to-back dumps.
module tb_dump_cntrl;

  localparam int ENTRIES = 384;
  localparam int LOG2    = 9;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            i_dump_en;
  logic [2:0]      i_dump_chan;
  logic [LOG2-1:0] i_waddr;
  logic [7:0]      i_rdata = 8'h00;
  logic            i_tx_done;
  logic [2:0]      o_ch_sel;
  logic [LOG2-1:0] o_raddr;
  logic            o_ren;
  logic [7:0]      o_tx_data;
  logic            o_trmt;
  logic            o_busy;
  logic            o_dump_done;

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] mem [0:7][0:511];

  dump_cntrl #(.ENTRIES(ENTRIES), .LOG2(LOG2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_dump_en  (i_dump_en),
    .i_dump_chan(i_dump_chan),
    .i_waddr    (i_waddr),
    .i_rdata    (i_rdata),
    .i_tx_done  (i_tx_done),
    .o_ch_sel   (o_ch_sel),
    .o_raddr    (o_raddr),
    .o_ren      (o_ren),
    .o_tx_data  (o_tx_data),
    .o_trmt     (o_trmt),
    .o_busy     (o_busy),
    .o_dump_done(o_dump_done)
  );

  always #5 clk = ~clk;

  // Registered-read channel RAM model, one cycle latency after ren.
  always @(posedge clk) begin
    if (o_ren) i_rdata <= mem[o_ch_sel][o_raddr];
  end

  function automatic logic [7:0] pat(input int c, input int a);
    int v;
    v = (c == 1) ? a : (a * c + 17 * c);
    return v[7:0];
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic check_idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk("idle_quiet", int'({o_busy, o_ren, o_trmt, o_dump_done}), 0);
    end
  endtask

  // mode 0: clean; 1: noisy inputs mid-dump; 2: async reset in TXWAIT of byte 100
  task automatic run_dump(input logic [2:0] ch, input int wa, input bit valid,
                          input int dly, input int mode);
    int cyc, nsent, nren, cnt, last_ren, last_txd;
    bit fin;
    @(negedge clk);
    i_dump_en = 1'b1; i_dump_chan = ch; i_waddr = LOG2'(wa);
    cyc = 0; nsent = 0; nren = 0; cnt = 0; last_ren = -100; last_txd = -100; fin = 1'b0;
    while (!fin && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      i_dump_en = 1'b0;
      i_tx_done = 1'b0;
      if (mode == 2 && nsent == 101 && cnt > 1) begin
        rst_n = 1'b0;
        #1;
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_ren", int'(o_ren), 0);
        chk("rst_trmt", int'(o_trmt), 0);
        chk("rst_done", int'(o_dump_done), 0);
        chk("rst_raddr", int'(o_raddr), 0);
        chk("rst_ch_sel", int'(o_ch_sel), 0);
        chk("rst_tx_data", int'(o_tx_data), 0);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (valid) chk("raddr_range", int'(o_raddr < LOG2'(ENTRIES)), 1);
      if (o_ren) begin
        if (valid) begin
          chk("raddr", int'(o_raddr), (wa + nren) % ENTRIES);
          chk("ch_sel", int'(o_ch_sel), int'(ch));
          if (nren == 0) chk("first_ren_cycle", cyc, 1);
        end else begin
          chk("inv_no_ren", 1, 0);
        end
        last_ren = cyc;
        nren++;
      end
      if (o_trmt) begin
        if (valid) begin
          chk("tx_data", int'(o_tx_data), int'(pat(ch, (wa + nsent) % ENTRIES)));
          chk("ren_to_trmt", cyc - last_ren, 2);
          if (nsent > 0) chk("txdone_to_trmt", cyc - last_txd, 3);
        end else begin
          chk("inv_no_trmt", 1, 0);
        end
        nsent++;
        cnt = dly;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          i_tx_done = 1'b1;
          last_txd = cyc;
        end
      end
      if (o_dump_done) begin
        fin = 1'b1;
        chk("done_busy", int'(o_busy), 0);
        if (valid) begin
          chk("done_latency", cyc - last_txd, 1);
          chk("byte_count", nsent, ENTRIES);
        end else begin
          chk("inv_done_latency", cyc, 1);
        end
      end else begin
        chk("busy", int'(o_busy), int'(valid));
      end
      if (mode == 1 && !fin) begin
        i_waddr = LOG2'($urandom_range(0, ENTRIES - 1));
        i_dump_chan = 3'($urandom_range(0, 7));
        if (cyc % 37 == 0) i_dump_en = 1'b1;
        if (o_ren && (nren % 3 == 1)) i_tx_done = 1'b1;
        if (o_trmt && (nsent % 3 == 0)) i_tx_done = 1'b1;
        if ((cyc == last_ren + 1) && (nren % 3 == 2)) i_tx_done = 1'b1;
      end
    end
    if (!fin) chk("timeout", 0, 1);
    i_dump_en = 1'b0;
    i_tx_done = 1'b0;
  endtask

  typedef struct {
    logic [2:0] ch;
    int         wa;
    bit         valid;
    int         dly;
  } vec_t;

  vec_t vecs [6];

  initial begin
    for (int c = 0; c < 8; c++)
      for (int a = 0; a < 512; a++)
        mem[c][a] = pat(c, a);

    vecs[0] = '{ch: 3'd1, wa: 0,   valid: 1'b1, dly: 10};
    vecs[1] = '{ch: 3'd3, wa: 380, valid: 1'b1, dly: 2};
    vecs[2] = '{ch: 3'd0, wa: 5,   valid: 1'b0, dly: 1};
    vecs[3] = '{ch: 3'd6, wa: 5,   valid: 1'b0, dly: 1};
    vecs[4] = '{ch: 3'd7, wa: 9,   valid: 1'b0, dly: 1};
    vecs[5] = '{ch: 3'd5, wa: 7,   valid: 1'b1, dly: 1};

    rst_n = 1'b0;
    i_dump_en = 1'b0; i_dump_chan = 3'd0; i_waddr = '0; i_tx_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_outputs", int'({o_busy, o_ren, o_trmt, o_dump_done}), 0);
    chk("reset_raddr", int'(o_raddr), 0);
    chk("reset_ch_sel", int'(o_ch_sel), 0);
    chk("reset_tx_data", int'(o_tx_data), 0);
    rst_n = 1'b1;
    check_idle(2);

    for (int i = 0; i < 6; i++) begin
      run_dump(vecs[i].ch, vecs[i].wa, vecs[i].valid, vecs[i].dly, 0);
      check_idle(2);
    end

    // Noisy dump: stray dump_en, tx_done outside TXWAIT, moving waddr/chan.
    run_dump(3'd4, 100, 1'b1, 4, 1);
    i_waddr = '0; i_dump_chan = 3'd0;
    check_idle(2);

    // Reset during byte 100, then a fresh dump from a new waddr.
    run_dump(3'd2, 50, 1'b1, 10, 2);
    check_idle(2);
    run_dump(3'd2, 200, 1'b1, 1, 0);
    check_idle(2);

    // Back-to-back: second dump_en the cycle after dump_done.
    run_dump(3'd1, 383, 1'b1, 1, 0);
    run_dump(3'd5, 7, 1'b1, 1, 0);
    check_idle(3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dump_cntrl.md
# dump_cntrl

Reads a completed capture out of the circular sample RAM and streams it, oldest sample first, to the UART transmitter one byte at a time. It sits between the command/config block, the channel RAMs and the UART TX. It is the read-side counterpart of the capture controller: it starts at the write pointer left behind when capture finished, and walks the full buffer once with wrap-around.

## Interface
- ENTRIES, 384, number of sample locations per channel RAM
- LOG2, 9, address width; must satisfy 2**LOG2 >= ENTRIES
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- dump_en  input  1  one-cycle start pulse from cmd_cfg
- dump_chan  input  3  channel to dump; valid values 1..5
- waddr  input  LOG2  capture write pointer; equals the oldest-sample address once capture is done
- rdata  input  8  read data from the selected channel RAM; registered, 1-cycle latency after ren
- tx_done  input  1  one-cycle pulse from UART TX when a byte finishes
- ch_sel  output  3  channel select for the RAM read mux, held for the whole dump
- raddr  output  LOG2  RAM read address
- ren  output  1  RAM read enable
- tx_data  output  8  byte presented to UART TX
- trmt  output  1  one-cycle transmit strobe to UART TX
- busy  output  1  high from the cycle after an accepted dump_en until dump_done
- dump_done  output  1  one-cycle pulse when the dump completes or is rejected

## Operation
- State machine states: IDLE, READ, LATCH, SEND, TXWAIT, DONE.
- IDLE:
  - On dump_en with dump_chan in 1..5: latch ch_sel<=dump_chan, raddr<=waddr, byte_cnt<=0, then go to READ.
  - On dump_en with dump_chan of 0, 6 or 7: go to DONE. No RAM read and no byte sent.
- READ: assert ren for one cycle at the current raddr, then go to LATCH.
- LATCH: rdata is valid. Register tx_data<=rdata, then go to SEND.
- SEND: assert trmt for exactly one cycle, then go to TXWAIT.
- TXWAIT:
  - Wait for tx_done.
  - On tx_done with byte_cnt == ENTRIES-1: go to DONE.
  - On tx_done otherwise: byte_cnt++ and go to READ. raddr<=0 if raddr == ENTRIES-1, else raddr+1.
- DONE: pulse dump_done for one cycle, drop busy, return to IDLE.
- Exactly ENTRIES bytes per valid dump, in address order starting at waddr and wrapping ENTRIES-1 -> 0.
- byte_cnt is LOG2 bits wide and never exceeds ENTRIES-1. raddr never takes values >= ENTRIES.
- dump_en outside IDLE is ignored. tx_done outside TXWAIT is ignored.
- waddr and dump_chan are sampled only on the accepting cycle. Later changes to them have no effect.

## Timing
- Reset values: state IDLE, ch_sel 0, raddr 0, ren 0, tx_data 0, trmt 0, busy 0, dump_done 0, byte_cnt 0. All outputs are registered or decoded from registered state.
- Cycle 0: dump_en is sampled.
- Cycle 1: busy=1 and ren=1 at raddr=waddr.
- Cycle 2: LATCH state.
- Cycle 3: trmt=1 with tx_data stable.
- tx_data holds from trmt until the next LATCH.
- Per-byte overhead outside the UART: 3 cycles, from tx_done to the next trmt.
- The cycle after the final tx_done: dump_done=1 and busy=0.
- Invalid channel: dump_done pulses 1 cycle after dump_en; busy stays 0.
- A tx_done arriving in the same cycle as trmt is not counted. Only tx_done seen while in TXWAIT advances the dump.
- Async reset mid-dump:
  - All outputs clear immediately and state returns to IDLE.
  - A trmt or dump_done pulse in progress is cut.
  - No partial resume after reset.

## Test plan
- Reset mid-stream: assert rst_n low during TXWAIT of byte 100 -> all outputs 0 within the reset cycle; a new dump_en afterwards restarts from the new waddr with byte_cnt 0.
- Basic dump, waddr=0, ch 1, RAM[i]=i[7:0], tx_done 10 cycles after each trmt -> 384 trmt pulses, bytes 0x00..0xFF,0x00..0x7F, ren-to-trmt 2 cycles, single dump_done, busy low afterwards.
- Wrap start, waddr=380, ch 3 -> read order 380,381,382,383,0,1,...,379; exactly 384 bytes; raddr never reaches 384.
- Invalid channel: dump_chan=0 and dump_chan=6 -> dump_done 1 cycle after dump_en, no ren, no trmt, busy stays 0.
- Ignored inputs:
  - dump_en pulses during an active dump -> no restart; byte order and count unchanged.
  - Spurious tx_done in READ/LATCH/SEND -> no skipped address.
  - waddr and dump_chan changing mid-dump -> no effect.
- Back-to-back dumps: second dump_en on the cycle after dump_done, ch 5, waddr=7 -> accepted, first ren at raddr 7, ch_sel=5.
